dac_scheduler: RTL and testbench

- Shares one dacsend SPI engine (LTC2624 quad 12-bit DAC) among four channel requesters, A–D.
- Each requester posts a 12-bit value at any time without stalling. Values are held in per-channel shadow registers with pending flags.
- A round-robin scheduler issues one dacsend transaction at a time over the dactrigsync/dactrigsyncack/dacdonesync handshake.
- Sits between application logic (waveform generators, test patterns) and dacsend, in the CLK50MHZ domain.

---
 rtl/dac_pkg.sv | 30 +++
 rtl/rr_arbiter4.sv | 30 +++
 rtl/dac_scheduler.sv | 179 +++++++++++++++++
 tb/tb_dac_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// dac_pkg : shared constants for the LTC2624 DAC path (commands, channel
//           addresses, widths, scheduler FSM state encoding).
// Revision: 1.0  initial release
// ============================================================================
package dac_pkg;

  localparam int DAC_W = 12;
  localparam int NCH   = 4;

  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_PWRDN        = 4'b0100;

  localparam logic [3:0] ADDR_A   = 4'd0;
  localparam logic [3:0] ADDR_B   = 4'd1;
  localparam logic [3:0] ADDR_C   = 4'd2;
  localparam logic [3:0] ADDR_D   = 4'd3;
  localparam logic [3:0] ADDR_ALL = 4'b1111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_TRIG      = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;
  localparam state_t ST_FINISH    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// rr_arbiter4 : combinational 4-way round-robin pick, searching upward from
//               the channel after last_i.
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_o,
  output logic       valid_o
);

  always_comb begin
    logic [1:0] idx;
    idx     = last_i;
    gnt_o   = last_i;
    valid_o = 1'b0;
    // i = 4 wraps back to last_i itself, so it is considered last.
    for (int i = 1; i <= 4; i++) begin
      idx = last_i + 2'(i);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        gnt_o   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_scheduler.sv
`default_nettype none
// ============================================================================
// dac_scheduler : shares one dacsend SPI engine among four coalescing channel
//                 requesters with round-robin issue.
// Optional: DAC_SCHEDULER_TIMEOUT_EN adds a handshake watchdog and err port.
// Revision: 1.0  initial release
// ============================================================================
module dac_scheduler
  import dac_pkg::*;
#(
  parameter logic [3:0] CMD = CMD_WRITE_UPDATE
`ifdef DAC_SCHEDULER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                   CLK50MHZ,
  input  logic                   RST,
  input  logic [NCH-1:0]         wr,
  input  logic [NCH*DAC_W-1:0]   wdata,
  output logic [NCH-1:0]         pending,
  output logic [NCH-1:0]         done,
  output logic                   busy,
  output logic [DAC_W-1:0]       data,
  output logic [3:0]             address,
  output logic [3:0]             command,
  output logic                   dactrigsync,
  input  logic                   dactrigsyncack,
  input  logic                   dacdonesync
`ifdef DAC_SCHEDULER_TIMEOUT_EN
  , output logic                 err
`endif
);

  state_t             state_q, state_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [1:0]         ch_q, ch_d;
  logic [NCH-1:0]     pending_q, pending_d;
  logic [NCH-1:0]     done_q, done_d;
  logic               busy_q, busy_d;
  logic [DAC_W-1:0]   data_q, data_d;
  logic               trig_q, trig_d;
  logic [DAC_W-1:0]   shadow_q [NCH];

  logic [1:0]         arb_gnt;
  logic               arb_valid;

`ifdef DAC_SCHEDULER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               tmo_hit;
  logic               tmo_fire;

  assign tmo_hit = ((state_q == ST_TRIG) || (state_q == ST_WAIT_DONE)) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  rr_arbiter4 u_arb (
    .req_i   (pending_q),
    .last_i  (last_grant_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    pending_d    = pending_q;
    done_d       = '0;
    busy_d       = busy_q;
    data_d       = data_q;
    trig_d       = trig_q;
`ifdef DAC_SCHEDULER_TIMEOUT_EN
    tmo_fire     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          data_d              = shadow_q[arb_gnt];
          ch_d                = arb_gnt;
          last_grant_d        = arb_gnt;
          pending_d[arb_gnt]  = 1'b0;
          trig_d              = 1'b1;
          busy_d              = 1'b1;
          state_d             = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (dactrigsyncack) begin
          trig_d  = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (dacdonesync) begin
          done_d[ch_q] = 1'b1;
          state_d      = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef DAC_SCHEDULER_TIMEOUT_EN
    // A genuine handshake edge wins over an expiry landing on the same cycle.
    if (tmo_hit && (state_d == state_q)) begin
      tmo_fire        = 1'b1;
      trig_d          = 1'b0;
      pending_d[ch_q] = 1'b1;
      state_d         = ST_FINISH;
    end
`endif
    // New writes always leave the channel pending, even on its grant edge.
    pending_d = pending_d | wr;
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'd3;
      ch_q         <= 2'd0;
      pending_q    <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      data_q       <= '0;
      trig_q       <= 1'b0;
      for (int n = 0; n < NCH; n++) shadow_q[n] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      data_q       <= data_d;
      trig_q       <= trig_d;
      for (int n = 0; n < NCH; n++) begin
        if (wr[n]) shadow_q[n] <= wdata[n*DAC_W +: DAC_W];
      end
    end
  end

`ifdef DAC_SCHEDULER_TIMEOUT_EN
  always_comb begin
    err_d = err_q | tmo_fire;
    if ((state_d != state_q) ||
        !((state_q == ST_TRIG) || (state_q == ST_WAIT_DONE))) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign pending     = pending_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign data        = data_q;
  assign address     = {2'b00, ch_q};
  assign command     = CMD;
  assign dactrigsync = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_scheduler.sv
`default_nettype none
// tb_dac_scheduler : directed table, hand-written corner sequences and a
// randomized run against a round-robin/coalescing reference model.
module tb_dac_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wr = '0;
  logic [47:0] wdata = '0;
  logic        ack = 1'b0;
  logic        dn = 1'b0;
  logic [3:0]  pending, done, address, command;
  logic        busy, dactrigsync;
  logic [11:0] data;
`ifdef DAC_SCHEDULER_TIMEOUT_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  dac_scheduler dut (
    .CLK50MHZ       (clk),
    .RST            (rst_n),
    .wr             (wr),
    .wdata          (wdata),
    .pending        (pending),
    .done           (done),
    .busy           (busy),
    .data           (data),
    .address        (address),
    .command        (command),
    .dactrigsync    (dactrigsync),
    .dactrigsyncack (ack),
    .dacdonesync    (dn)
`ifdef DAC_SCHEDULER_TIMEOUT_EN
    , .err          (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input int ch, input logic [11:0] v);
    wr        = '0;
    wr[ch]    = 1'b1;
    wdata     = '0;
    wdata[ch*12 +: 12] = v;
  endtask

  // Plays dacsend for one transaction and checks the full handshake.
  task automatic do_txn(input string name, input int ch, input logic [11:0] v);
    logic [3:0] oh;
    oh = 4'(1) << ch;
    for (int c = 0; c < 32; c++) begin
      if (dactrigsync) break;
      tick();
    end
    chk({name, " trig"}, 32'(dactrigsync), 32'd1);
    chk({name, " address"}, 32'(address), 32'(ch));
    chk({name, " data"}, 32'(data), 32'(v));
    chk({name, " command"}, 32'(command), 32'h3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({name, " trig drop"}, 32'(dactrigsync), 32'd0);
    tick();
    chk({name, " no early done"}, 32'(done), 32'd0);
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk({name, " done"}, 32'(done), 32'(oh));
    chk({name, " busy in finish"}, 32'(busy), 32'd1);
    tick();
    chk({name, " done clear"}, 32'(done), 32'd0);
    chk({name, " busy clear"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " pending"}, 32'(pending), 32'd0);
    chk({name, " done"}, 32'(done), 32'd0);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " data"}, 32'(data), 32'd0);
    chk({name, " address"}, 32'(address), 32'd0);
    chk({name, " trig"}, 32'(dactrigsync), 32'd0);
    chk({name, " command"}, 32'(command), 32'h3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr = '0; ack = 1'b0; dn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  typedef struct {
    int         ch;
    logic [11:0] val;
    logic [3:0]  exp_addr;
    logic [3:0]  exp_pend;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic        seen;
    logic [11:0] m_shadow [4];
    logic [3:0]  m_pend, exp_done, wr_s;
    logic [47:0] wd_s;
    int          m_last, cur, g;
    bit          in_wait, prev_trig;

    vecs[0] = '{ch: 2, val: 12'hABC, exp_addr: 4'h2, exp_pend: 4'b0100};
    vecs[1] = '{ch: 0, val: 12'h000, exp_addr: 4'h0, exp_pend: 4'b0001};
    vecs[2] = '{ch: 3, val: 12'hFFF, exp_addr: 4'h3, exp_pend: 4'b1000};
    vecs[3] = '{ch: 1, val: 12'h5A5, exp_addr: 4'h1, exp_pend: 4'b0010};

    tick();
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      write1(vecs[i].ch, vecs[i].val);
      tick();
      wr = '0;
      chk($sformatf("vec%0d pending set", i), 32'(pending), 32'(vecs[i].exp_pend));
      chk($sformatf("vec%0d trig not yet", i), 32'(dactrigsync), 32'd0);
      tick();
      chk($sformatf("vec%0d trig latency", i), 32'(dactrigsync), 32'd1);
      chk($sformatf("vec%0d addr", i), 32'(address), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d pending clr", i), 32'(pending), 32'd0);
      do_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].val);
    end

    // Four simultaneous writes from reset: order 0,1,2,3.
    do_reset();
    wr = 4'hF;
    wdata = {12'h444, 12'h333, 12'h222, 12'h111};
    tick();
    wr = '0;
    do_txn("rr0 ch0", 0, 12'h111);
    do_txn("rr0 ch1", 1, 12'h222);
    do_txn("rr0 ch2", 2, 12'h333);
    do_txn("rr0 ch3", 3, 12'h444);

    // After a lone ch1 transaction the order becomes 2,3,0,1.
    write1(1, 12'h0F1);
    tick();
    wr = '0;
    do_txn("pre ch1", 1, 12'h0F1);
    wr = 4'hF;
    wdata = {12'h444, 12'h333, 12'h222, 12'h111};
    tick();
    wr = '0;
    do_txn("rr1 ch2", 2, 12'h333);
    do_txn("rr1 ch3", 3, 12'h444);
    do_txn("rr1 ch0", 0, 12'h111);
    do_txn("rr1 ch1", 1, 12'h222);

    // Coalescing: three ch1 writes while ch0 is in flight.
    write1(0, 12'h0AA);
    tick();
    wr = '0;
    tick();
    chk("coal ch0 trig", 32'(dactrigsync), 32'd1);
    write1(1, 12'h001); tick();
    write1(1, 12'h002); tick();
    write1(1, 12'h003); tick();
    wr = '0;
    chk("coal pending", 32'(pending), 32'b0010);
    chk("coal data held", 32'(data), 32'h0AA);
    do_txn("coal ch0", 0, 12'h0AA);
    do_txn("coal ch1", 1, 12'h003);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen |= dactrigsync;
    end
    chk("coal single txn", 32'(seen), 32'd0);
    chk("coal pending empty", 32'(pending), 32'd0);

    // Grant collision on ch0.
    write1(0, 12'h444);
    tick();
    write1(0, 12'h555);
    tick();
    wr = '0;
    chk("coll trig", 32'(dactrigsync), 32'd1);
    chk("coll data old", 32'(data), 32'h444);
    chk("coll pending kept", 32'(pending), 32'b0001);
    do_txn("coll first", 0, 12'h444);
    do_txn("coll second", 0, 12'h555);

    // Reset while in WAIT_DONE with ch1/ch3 pending.
    write1(0, 12'h123);
    tick();
    wr = '0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wr = 4'b1010;
    wdata = {12'h777, 12'h666, 12'h555, 12'h444};
    tick();
    wr = '0;
    chk("midrst pending", 32'(pending), 32'b1010);
    chk("midrst busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst async");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen |= dactrigsync;
    end
    chk("midrst no restart", 32'(seen), 32'd0);
    chk("midrst pending lost", 32'(pending), 32'd0);
    wr = 4'hF;
    wdata = {12'hD04, 12'hC03, 12'hB02, 12'hA01};
    tick();
    wr = '0;
    do_txn("postrst ch0", 0, 12'hA01);
    do_txn("postrst ch1", 1, 12'hB02);
    do_txn("postrst ch2", 2, 12'hC03);
    do_txn("postrst ch3", 3, 12'hD04);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 4; n++) m_shadow[n] = '0;
    m_pend = '0; m_last = 3; cur = 0; in_wait = 0; prev_trig = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 4; n++) wr[n] = ($urandom_range(0, 5) == 0);
      wdata[31:0]  = $urandom();
      wdata[47:32] = 16'($urandom());
      ack = dactrigsync ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      dn  = in_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      exp_done = (in_wait && dn) ? (4'(1) << cur) : 4'd0;
      wr_s = wr;
      wd_s = wdata;
      tick();
      if (dactrigsync && !prev_trig) begin
        g = rr_pick(m_pend, m_last);
        if (g < 0) begin
          chk("rand grant without pending", 32'(dactrigsync), 32'd0);
        end else begin
          chk("rand address", 32'(address), 32'(g));
          chk("rand data", 32'(data), 32'(m_shadow[g]));
          m_pend[g] = 1'b0;
          m_last = g;
          cur = g;
        end
      end
      if (prev_trig && !dactrigsync) in_wait = 1;
      if (exp_done != 0) in_wait = 0;
      for (int n = 0; n < 4; n++) begin
        if (wr_s[n]) begin
          m_shadow[n] = wd_s[n*12 +: 12];
          m_pend[n]   = 1'b1;
        end
      end
      chk("rand pending", 32'(pending), 32'(m_pend));
      chk("rand done", 32'(done), 32'(exp_done));
      prev_trig = dactrigsync;
    end
    wr = '0; ack = 1'b0; dn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
